// File: rtl/md_unit.sv
// ============================================================================
//  Module   : md_unit
//  Brief    : Multi-cycle multiply/divide unit with HI/LO registers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [1:0]       mdwe,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int c_max_cyc = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_cnt_w   = $clog2(c_max_cyc + 1);
  localparam logic [c_cnt_w-1:0] c_mult_n  = c_cnt_w'(MULT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_div_n   = c_cnt_w'(DIV_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo, r_hi_p, r_lo_p;
  logic               r_done;
  logic               w_launch, w_commit, w_abort, w_mt_wr;

  logic               w_is_div, w_is_signed;
  logic [2*WIDTH-1:0] w_mul_a, w_mul_b, w_prod;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_b_safe, w_q_mag, w_r_mag;
  logic [WIDTH-1:0]   w_res_hi, w_res_lo;

  // Result is formed from the launch-cycle operands and parked until commit.
  always_comb begin
    w_is_div    = md_op[0];
    w_is_signed = md_op[1];
    w_mul_a = w_is_signed ? {{WIDTH{rs_data[WIDTH-1]}}, rs_data} : {{WIDTH{1'b0}}, rs_data};
    w_mul_b = w_is_signed ? {{WIDTH{rt_data[WIDTH-1]}}, rt_data} : {{WIDTH{1'b0}}, rt_data};
    w_prod  = w_mul_a * w_mul_b;

    // Sign-magnitude divide: truncation toward zero, remainder follows dividend.
    w_a_neg  = w_is_signed & rs_data[WIDTH-1];
    w_b_neg  = w_is_signed & rt_data[WIDTH-1];
    w_a_mag  = w_a_neg ? -rs_data : rs_data;
    w_b_mag  = w_b_neg ? -rt_data : rt_data;
    w_b_safe = (rt_data == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_b_mag;
    w_q_mag  = w_a_mag / w_b_safe;
    w_r_mag  = w_a_mag % w_b_safe;

    if (!w_is_div) begin
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end else if (rt_data == '0) begin
      w_res_hi = rs_data;
      w_res_lo = '1;
    end else begin
      w_res_hi = w_a_neg ? -w_r_mag : w_r_mag;
      w_res_lo = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_commit    = 1'b0;
    w_abort     = 1'b0;
    w_mt_wr     = 1'b0;
    if (r_state == S_IDLE) begin
      if (start && !flush) begin
        w_launch    = 1'b1;
        w_state_nxt = S_RUN;
      end else if (!start && !flush) begin
        w_mt_wr = 1'b1;
      end
    end else begin
      if (flush) begin
        w_abort     = 1'b1;
        w_state_nxt = S_IDLE;
      end else if (r_cnt == c_cnt_one) begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_hi_p  <= '0;
      r_lo_p  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_commit;

      if (w_launch) begin
        r_cnt  <= w_is_div ? c_div_n : c_mult_n;
        r_hi_p <= w_res_hi;
        r_lo_p <= w_res_lo;
      end else if (w_abort || w_commit) begin
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt - c_cnt_one;
      end

      if (w_commit) begin
        r_hi <= r_hi_p;
        r_lo <= r_lo_p;
      end else if (w_mt_wr) begin
        if (mdwe[0]) r_hi <= rs_data;
        if (mdwe[1]) r_lo <= rs_data;
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

`default_nettype wire
